deframer: RTL and testbench

- Receiver-side inverse of the transmitter framer.
- Accepts a byte-serial stream of 256-bit frames laid out as {timestamp[31:0], length[7:0], message[215:0]}, sent MSB byte first.
- Reassembles each frame, splits it into fields, and checks length and timestamp freshness.
- Presents the fields plus framed+1 (the authentication copy) to the receiver's authentication stage over a valid/ready handshake.

---
 rtl/deframer_pkg.sv | 38 +++
 rtl/deframer_check.sv | 39 +++
 rtl/deframer.sv | 134 +++++++++++++
 tb/tb_deframer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deframer_pkg.sv
// Frame layout and shared types for the framer/deframer pair.
// Frames are {timestamp, length, message}, sent MSB byte first.
package deframer_pkg;

    localparam int FRAME_BITS  = 256;
    localparam int TS_BITS     = 32;
    localparam int LEN_BITS    = 8;
    localparam int MSG_BITS    = 216;
    localparam int FRAME_BYTES = FRAME_BITS / 8;

    // Field offsets are derived from the widths so both ends stay in step.
    localparam int MSG_LSB = 0;
    localparam int LEN_LSB = MSG_LSB + MSG_BITS;
    localparam int TS_LSB  = LEN_LSB + LEN_BITS;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_STALE   = 2'd3
    } err_code_t;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t CHECK   = 2'd2;
    localparam state_t OUTPUT  = 2'd3;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [TS_BITS-1:0]  ts,
        input logic [LEN_BITS-1:0] len,
        input logic [MSG_BITS-1:0] msg
    );
        return {ts, len, msg};
    endfunction

endpackage

// File: rtl/deframer_check.sv
// Combinational frame validation: length limit and timestamp freshness,
// plus the +1 authentication copy of the frame.
module deframer_check
    import deframer_pkg::*;
#(
    parameter int MAX_LEN = 27,
    parameter int MAX_AGE = 1000
) (
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [TS_BITS-1:0]    current_time,
    output err_code_t             err_code,
    output logic [FRAME_BITS-1:0] frame_inc
);

    localparam logic [LEN_BITS-1:0] LEN_LIMIT = LEN_BITS'(MAX_LEN);
    localparam logic [TS_BITS-1:0]  AGE_LIMIT = TS_BITS'(MAX_AGE);

    logic [TS_BITS-1:0] age;
    logic               len_bad;
    logic               stale;

    // Modulo-2^32 subtraction keeps the age correct across counter wrap.
    always_comb begin
        age     = current_time - frame[TS_LSB +: TS_BITS];
        len_bad = frame[LEN_LSB +: LEN_BITS] > LEN_LIMIT;
        stale   = age > AGE_LIMIT;

        if (len_bad) begin
            err_code = ERR_LEN;
        end else if (stale) begin
            err_code = ERR_STALE;
        end else begin
            err_code = ERR_NONE;
        end

        frame_inc = frame + FRAME_BITS'(1);
    end

endmodule

// File: rtl/deframer.sv
// Byte-serial frame receiver: reassembles a frame, validates it, and hands
// the fields plus the +1 authentication copy downstream over valid/ready.
module deframer
    import deframer_pkg::*;
#(
    parameter int MAX_LEN        = 27,
    parameter int MAX_AGE        = 1000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [TS_BITS-1:0]    current_time,
    output logic [TS_BITS-1:0]    timestamp,
    output logic [LEN_BITS-1:0]   length,
    output logic [MSG_BITS-1:0]   message,
    output logic [FRAME_BITS-1:0] framed_message,
    output logic [FRAME_BITS-1:0] modified_framed_message,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_valid,
    output logic [1:0]            err_code
);

    localparam int                TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]        BYTE_LAST = 6'(FRAME_BYTES - 1);

    state_t                state;
    logic [5:0]            byte_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  accept;
    err_code_t             chk_code;
    logic [FRAME_BITS-1:0] frame_inc;

    assign rx_ready = (state == IDLE) || (state == COLLECT);
    assign accept   = rx_valid && rx_ready;

    deframer_check #(
        .MAX_LEN (MAX_LEN),
        .MAX_AGE (MAX_AGE)
    ) u_check (
        .frame        (frame),
        .current_time (current_time),
        .err_code     (chk_code),
        .frame_inc    (frame_inc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            byte_cnt                <= '0;
            to_cnt                  <= '0;
            frame                   <= '0;
            timestamp               <= '0;
            length                  <= '0;
            message                 <= '0;
            framed_message          <= '0;
            modified_framed_message <= '0;
            out_valid               <= 1'b0;
            err_valid               <= 1'b0;
            err_code                <= ERR_NONE;
        end else begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;

            if (accept) begin
                frame <= {frame[FRAME_BITS-9:0], rx_data};
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        byte_cnt <= 6'd1;
                        to_cnt   <= '0;
                        state    <= COLLECT;
                    end
                end

                // A partial frame that stalls too long is dropped with a timeout.
                COLLECT: begin
                    if (accept) begin
                        to_cnt <= '0;
                        if (byte_cnt == BYTE_LAST) begin
                            byte_cnt <= '0;
                            state    <= CHECK;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        byte_cnt  <= '0;
                        to_cnt    <= '0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                CHECK: begin
                    if (chk_code != ERR_NONE) begin
                        err_valid <= 1'b1;
                        err_code  <= chk_code;
                        state     <= IDLE;
                    end else begin
                        timestamp               <= frame[TS_LSB +: TS_BITS];
                        length                  <= frame[LEN_LSB +: LEN_BITS];
                        message                 <= frame[MSG_LSB +: MSG_BITS];
                        framed_message          <= frame;
                        modified_framed_message <= frame_inc;
                        out_valid               <= 1'b1;
                        state                   <= OUTPUT;
                    end
                end

                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deframer.sv
// Self-checking bench for deframer: a byte-queue reference model compared
// every cycle, plus literal expectations on key results.
module tb_deframer;
    import deframer_pkg::*;

    localparam logic [255:0] F_GOOD  = {32'h0000_0100, 8'h10, {27{8'hA5}}};
    localparam logic [255:0] F_GOOD1 = {32'h0000_0100, 8'h10, {26{8'hA5}}, 8'hA6};
    localparam logic [255:0] F_LEN28 = {32'h0000_0100, 8'd28, {27{8'h3C}}};
    localparam logic [255:0] F_BOTH  = {32'h0000_0100, 8'hFF, {27{8'h11}}};
    localparam logic [255:0] F_WRAP  = {32'hFFFF_FF00, 8'h05, {27{8'h5A}}};
    localparam logic [255:0] F_EDGE  = {32'h0000_1000, 8'd27, {27{8'hC3}}};
    localparam logic [255:0] F_ONES  = {256{1'b1}};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_valid2 = 1'b0;
    logic [31:0]  current_time = 32'h0;
    logic         out_ready = 1'b0;
    logic         out_ready2 = 1'b0;

    logic         rx_ready, out_valid, err_valid;
    logic [1:0]   err_code;
    logic [31:0]  timestamp;
    logic [7:0]   length;
    logic [215:0] message;
    logic [255:0] framed_message, modified_framed_message;

    logic         rx_ready2, out_valid2, err_valid2;
    logic [1:0]   err_code2;
    logic [31:0]  timestamp2;
    logic [7:0]   length2;
    logic [215:0] message2;
    logic [255:0] framed2, modified2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    deframer dut (
        .clk                     (clk),
        .reset                   (reset),
        .rx_data                 (rx_data),
        .rx_valid                (rx_valid),
        .rx_ready                (rx_ready),
        .current_time            (current_time),
        .timestamp               (timestamp),
        .length                  (length),
        .message                 (message),
        .framed_message          (framed_message),
        .modified_framed_message (modified_framed_message),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .err_valid               (err_valid),
        .err_code                (err_code)
    );

    // Second instance with the length limit opened up for the all-ones frame.
    deframer #(.MAX_LEN(255)) dut_ones (
        .clk                     (clk),
        .reset                   (reset),
        .rx_data                 (rx_data),
        .rx_valid                (rx_valid2),
        .rx_ready                (rx_ready2),
        .current_time            (current_time),
        .timestamp               (timestamp2),
        .length                  (length2),
        .message                 (message2),
        .framed_message          (framed2),
        .modified_framed_message (modified2),
        .out_valid               (out_valid2),
        .out_ready               (out_ready2),
        .err_valid               (err_valid2),
        .err_code                (err_code2)
    );

    // Reference model for the main instance: bytes pile up in a queue, a full
    // queue is judged one cycle later, a good frame is held until taken.
    logic [7:0]   q[$];
    int           idle_cnt;
    int           phase;
    logic         m_rx_ready, m_out_valid, m_err_valid;
    logic [1:0]   m_err_code;
    logic [255:0] m_frame, m_inc;

    task automatic model_reset();
        q.delete();
        idle_cnt    = 0;
        phase       = 0;
        m_rx_ready  = 1'b1;
        m_out_valid = 1'b0;
        m_err_valid = 1'b0;
        m_err_code  = 2'd0;
        m_frame     = '0;
        m_inc       = '0;
    endtask

    task automatic model_step();
        logic [255:0] f;
        logic [31:0]  age;
        m_err_valid = 1'b0;
        m_err_code  = 2'd0;
        case (phase)
            0: begin
                if (rx_valid && m_rx_ready) begin
                    q.push_back(rx_data);
                    idle_cnt = 0;
                    if (q.size() == 32) phase = 1;
                end else if (q.size() > 0) begin
                    idle_cnt++;
                    if (idle_cnt == 64) begin
                        m_err_valid = 1'b1;
                        m_err_code  = 2'd1;
                        q.delete();
                        idle_cnt = 0;
                    end
                end
            end
            1: begin
                f = '0;
                foreach (q[i]) f = {f[247:0], q[i]};
                q.delete();
                age = current_time - f[255:224];
                phase = 0;
                if (f[223:216] > 8'd27) begin
                    m_err_valid = 1'b1;
                    m_err_code  = 2'd2;
                end else if (age > 32'd1000) begin
                    m_err_valid = 1'b1;
                    m_err_code  = 2'd3;
                end else begin
                    m_frame     = f;
                    m_inc       = f + 256'd1;
                    m_out_valid = 1'b1;
                    phase       = 2;
                end
            end
            default: begin
                if (out_ready) begin
                    m_out_valid = 1'b0;
                    phase       = 0;
                end
            end
        endcase
        m_rx_ready = (phase == 0);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("rx_ready", 256'(rx_ready), 256'(m_rx_ready));
            check("out_valid", 256'(out_valid), 256'(m_out_valid));
            check("err_valid", 256'(err_valid), 256'(m_err_valid));
            check("err_code", 256'(err_code), 256'(m_err_code));
            check("timestamp", 256'(timestamp), 256'(m_frame[255:224]));
            check("length", 256'(length), 256'(m_frame[223:216]));
            check("message", 256'(message), 256'(m_frame[215:0]));
            check("framed_message", framed_message, m_frame);
            check("modified_framed_message", modified_framed_message, m_inc);
        end
    end

    task automatic send_byte(input bit second, input logic [7:0] b);
        int guard = 0;
        rx_data = b;
        if (second) rx_valid2 = 1'b1;
        else rx_valid = 1'b1;
        while (((second ? rx_ready2 : rx_ready) !== 1'b1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rx_ready_wait: got 0 for 200 cycles, expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input bit second, input logic [255:0] f, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(second, f[255-8*i -: 8]);
        rx_valid  = 1'b0;
        rx_valid2 = 1'b0;
    endtask

    // Called on the CHECK-cycle negedge right after the last byte.
    task automatic expect_good(input string name, input logic [255:0] f);
        check({name, "_check_rx_ready"}, 256'(rx_ready), 256'(0));
        check({name, "_check_out_valid"}, 256'(out_valid), 256'(0));
        @(negedge clk);
        check({name, "_out_valid"}, 256'(out_valid), 256'(1));
        check({name, "_frame"}, framed_message, f);
    endtask

    task automatic expect_err(input string name, input logic [1:0] code);
        @(negedge clk);
        check({name, "_err_valid"}, 256'(err_valid), 256'(1));
        check({name, "_err_code"}, 256'(err_code), 256'(code));
        check({name, "_no_out_valid"}, 256'(out_valid), 256'(0));
        @(negedge clk);
        check({name, "_err_pulse_end"}, 256'(err_valid), 256'(0));
    endtask

    task automatic release_output(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_handshake_out_valid"}, 256'(out_valid), 256'(0));
        check({name, "_handshake_rx_ready"}, 256'(rx_ready), 256'(1));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_rx_ready", 256'(rx_ready), 256'(1));
        check("reset_out_valid", 256'(out_valid), 256'(0));
        check("reset_framed", framed_message, 256'(0));
        #2 reset = 1'b0;
        @(negedge clk);

        // Good frame, held a few cycles before the handshake.
        current_time = 32'h0000_0200;
        send_frame(0, F_GOOD, 32);
        expect_good("good", F_GOOD);
        check("good_timestamp", 256'(timestamp), 256'(32'h100));
        check("good_length", 256'(length), 256'(8'h10));
        check("good_modified", modified_framed_message, F_GOOD1);
        repeat (3) @(negedge clk);
        check("good_held", 256'(out_valid), 256'(1));
        release_output("good");

        send_frame(0, F_LEN28, 32);
        expect_err("badlen", 2'd2);

        current_time = 32'h0000_0100 + 32'd5000;
        send_frame(0, F_BOTH, 32);
        expect_err("both", 2'd2);

        current_time = 32'h0000_0010;
        send_frame(0, F_WRAP, 32);
        expect_good("wrap_pass", F_WRAP);
        release_output("wrap_pass");
        current_time = 32'h0000_0400;
        send_frame(0, F_WRAP, 32);
        expect_err("wrap_stale", 2'd3);

        // Age exactly at the limit passes; one beyond is stale.
        current_time = 32'h0000_1000 + 32'd1000;
        send_frame(0, F_EDGE, 32);
        expect_good("age_limit", F_EDGE);
        release_output("age_limit");
        current_time = 32'h0000_1000 + 32'd1001;
        send_frame(0, F_EDGE, 32);
        expect_err("age_over", 2'd3);

        // Timeout after a partial frame, then a clean full frame.
        current_time = 32'h0000_0200;
        send_frame(0, F_GOOD, 10);
        cnt = 0;
        while (err_valid !== 1'b1 && cnt < 80) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", 256'(cnt), 256'(64));
        check("timeout_code", 256'(err_code), 256'(1));
        send_frame(0, F_GOOD, 32);
        expect_good("after_timeout", F_GOOD);

        // Backpressure: bytes offered while the frame is held are refused.
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_rx_ready", 256'(rx_ready), 256'(0));
            check("bp_frame", framed_message, F_GOOD);
        end
        rx_valid = 1'b0;
        release_output("bp");

        // Asynchronous reset in the middle of a frame.
        current_time = 32'h0000_0010;
        send_frame(0, F_WRAP, 15);
        #2 reset = 1'b1;
        #1;
        check("rst_framed", framed_message, 256'(0));
        check("rst_modified", modified_framed_message, 256'(0));
        check("rst_timestamp", 256'(timestamp), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_err_code", 256'(err_code), 256'(0));
        check("rst_rx_ready", 256'(rx_ready), 256'(1));
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        send_frame(0, F_WRAP, 32);
        expect_good("after_reset", F_WRAP);
        release_output("after_reset");

        // All-ones frame on the relaxed-length instance: +1 wraps to zero.
        current_time = 32'hFFFF_FFFF;
        send_frame(1, F_ONES, 32);
        @(negedge clk);
        check("ones_out_valid", 256'(out_valid2), 256'(1));
        check("ones_framed", framed2, F_ONES);
        check("ones_modified", modified2, 256'(0));
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("ones_handshake", 256'(out_valid2), 256'(0));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
